// File: rtl/data_memory.sv
// Data-side OBI slave: word-organised RAM with byte-enable writes plus a 16-byte MMIO block
// (console TX, free-running cycle counter, halt/exit register). One outstanding transaction.
module data_memory #(
  parameter int unsigned MEM_WORDS   = 4096,
  parameter logic [31:0] RAM_BASE    = 32'h0010_0000,
  parameter logic [31:0] MMIO_BASE   = 32'h2000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  output logic        gnt,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        sim_done,
  output logic [31:0] exit_code,
  output logic        bus_fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned AW           = $clog2(MEM_WORDS);
  localparam logic [31:0] RamBytes     = 32'(MEM_WORDS * 4);
  localparam logic [3:0]  WaitCnt      = 4'(WAIT_STATES);
  localparam logic [31:0] UnmappedData = 32'hDEAD_BEEF;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam logic [1:0] OffConsole = 2'd0;
  localparam logic [1:0] OffCycle   = 2'd1;
  localparam logic [1:0] OffHalt    = 2'd2;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]   ram_off;
  logic          ram_hit;
  logic [AW-1:0] ram_idx;
  logic          mmio_hit;
  logic [1:0]    mmio_off;
  logic          unused_ram_off;

  assign ram_off  = addr - RAM_BASE;
  assign ram_hit  = (addr >= RAM_BASE) && (ram_off < RamBytes);
  assign ram_idx  = ram_off[AW+1:2];
  assign mmio_hit = (addr[31:4] == MMIO_BASE[31:4]);
  assign mmio_off = addr[3:2];

  // Byte offset within the word and bits above the RAM window play no part in indexing.
  assign unused_ram_off = ^{ram_off[31:AW+2], ram_off[1:0]};

  // ---------------------------------------------------------------------------
  // Grant FSM
  // ---------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      StIdle: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'd1;
          end
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == WaitCnt) begin
          gnt     = 1'b1;
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
    if (!rst_n) begin
      gnt = 1'b0;
    end
  end

  assign fire = req & gnt;

  // ---------------------------------------------------------------------------
  // RAM array (contents are deliberately not reset)
  // ---------------------------------------------------------------------------
  logic [31:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (rst_n && fire && we && ram_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[ram_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response and MMIO state
  // ---------------------------------------------------------------------------
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        sim_done_q, sim_done_d;
  logic [31:0] exit_code_q, exit_code_d;
  logic        bus_fault_q, bus_fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] cycle_q, cycle_d;

  always_comb begin
    rvalid_d     = fire;
    rdata_d      = rdata_q;
    tx_valid_d   = 1'b0;
    tx_data_d    = tx_data_q;
    sim_done_d   = sim_done_q;
    exit_code_d  = exit_code_q;
    bus_fault_d  = bus_fault_q;
    fault_addr_d = fault_addr_q;
    cycle_d      = cycle_q + 32'd1;

    if (fire) begin
      if (ram_hit) begin
        if (!we) begin
          rdata_d = mem[ram_idx];
        end
      end else if (mmio_hit) begin
        case (mmio_off)
          OffConsole: begin
            if (we) begin
              if (be[0]) begin
                tx_valid_d = 1'b1;
                tx_data_d  = wdata[7:0];
              end
            end else begin
              rdata_d = '0;
            end
          end
          OffCycle: begin
            if (!we) begin
              rdata_d = cycle_q;
            end
          end
          OffHalt: begin
            if (we) begin
              sim_done_d  = 1'b1;
              exit_code_d = wdata;
            end else begin
              rdata_d = {31'b0, sim_done_q};
            end
          end
          default: begin
            if (!we) begin
              rdata_d = '0;
            end
          end
        endcase
      end else begin
        // Unmapped: the response is still given so the core never stalls on a bad pointer.
        if (!we) begin
          rdata_d = UnmappedData;
        end
        if (!bus_fault_q) begin
          bus_fault_d  = 1'b1;
          fault_addr_d = addr;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= 4'd0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      sim_done_q   <= 1'b0;
      exit_code_q  <= '0;
      bus_fault_q  <= 1'b0;
      fault_addr_q <= '0;
      cycle_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      sim_done_q   <= sim_done_d;
      exit_code_q  <= exit_code_d;
      bus_fault_q  <= bus_fault_d;
      fault_addr_q <= fault_addr_d;
      cycle_q      <= cycle_d;
    end
  end

  assign rvalid     = rvalid_q;
  assign rdata      = rdata_q;
  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign sim_done   = sim_done_q;
  assign exit_code  = exit_code_q;
  assign bus_fault  = bus_fault_q;
  assign fault_addr = fault_addr_q;

endmodule
